// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between a priority
//   single-cycle writeback source (A) and a buffered multi-cycle source (B).
//   B requests sit in a small FIFO and drain when A leaves the port idle.
//   A starvation counter forces one B grant after MAX_WAIT ungranted cycles.
//   A is held off while an older B write to the same register is still
//   buffered, so writes to one register land in program order.
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   a_valid_i/a_ready_o        source A handshake (a_ready_o combinational)
//   a_addr_i/a_data_i          source A destination and data
//   b_valid_i/b_ready_o        source B handshake (b_ready_o = FIFO not full)
//   b_addr_i/b_data_i          source B destination and data
//   Reg_Write_o, Write_Register_o, Write_Data_o   registered RF write port
//   grant_b_o                  registered: current write came from B
//   pending_o                  registers targeted by buffered B entries
//   fifo_count_o               B FIFO occupancy
module regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               a_valid_i,
  output logic                               a_ready_o,
  input  logic [ADDR_W-1:0]                  a_addr_i,
  input  logic [DATA_W-1:0]                  a_data_i,
  input  logic                               b_valid_i,
  output logic                               b_ready_o,
  input  logic [ADDR_W-1:0]                  b_addr_i,
  input  logic [DATA_W-1:0]                  b_data_i,
  output logic                               Reg_Write_o,
  output logic [ADDR_W-1:0]                  Write_Register_o,
  output logic [DATA_W-1:0]                  Write_Data_o,
  output logic                               grant_b_o,
  output logic [(1<<ADDR_W)-1:0]             pending_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int WW   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {NORMAL = 1'b0, FORCE_B = 1'b1} state_t;

  wb_req_t                 mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   ent_vld;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic [WW-1:0]           wait_cnt;
  state_t                  state;

  logic    push, pop, grant_a, fifo_ne;
  wb_req_t head;

  assign fifo_ne      = (count != '0);
  assign b_ready_o    = (count != CW'(FIFO_DEPTH));
  assign fifo_count_o = count;
  assign head         = mem[rd_ptr];

  // Pending mask: one-hot decode of every occupied slot. x0 never hazards.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_vld[i]) pending_o[mem[i].addr] = 1'b1;
    pending_o[0] = 1'b0;
  end

  assign a_ready_o = (state != FORCE_B) && !((a_addr_i != '0) && pending_o[a_addr_i]);
  assign grant_a   = a_valid_i && a_ready_o;
  // Pop uses registered occupancy only: a same-cycle push is never visible.
  assign pop       = !grant_a && fifo_ne;
  assign push      = b_valid_i && b_ready_o;

  // Payload storage needs no reset; ent_vld qualifies it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: b_addr_i, data: b_data_i};
  end

  // Push and pop never hit the same slot: a push implies not full, a pop
  // implies not empty, so wr_ptr == rd_ptr cannot hold for both at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_vld <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Starvation FSM. In FORCE_B the FIFO is guaranteed non-empty (nothing
  // pops it while B is being starved), so the forced cycle always grants B.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (!fifo_ne || pop) begin
            wait_cnt <= '0;
          end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
            state    <= FORCE_B;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= NORMAL;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Write port register: one cycle from grant to Reg_Write_o.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Reg_Write_o      <= 1'b0;
      Write_Register_o <= '0;
      Write_Data_o     <= '0;
      grant_b_o        <= 1'b0;
    end else if (grant_a) begin
      Reg_Write_o      <= (a_addr_i != '0);
      Write_Register_o <= a_addr_i;
      Write_Data_o     <= a_data_i;
      grant_b_o        <= 1'b0;
    end else if (pop) begin
      Reg_Write_o      <= (head.addr != '0);
      Write_Register_o <= head.addr;
      Write_Data_o     <= head.data;
      grant_b_o        <= 1'b1;
    end else begin
      Reg_Write_o      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid_i = 1'b0, b_valid_i = 1'b0;
  logic [4:0]  a_addr_i = '0, b_addr_i = '0;
  logic [31:0] a_data_i = '0, b_data_i = '0;
  logic        a_ready_o, b_ready_o, Reg_Write_o, grant_b_o;
  logic [4:0]  Write_Register_o;
  logic [31:0] Write_Data_o, pending_o;
  logic [1:0]  fifo_count_o;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
    .Reg_Write_o(Reg_Write_o), .Write_Register_o(Write_Register_o), .Write_Data_o(Write_Data_o),
    .grant_b_o(grant_b_o), .pending_o(pending_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; registered outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid_i = 1'b0; b_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (Reg_Write_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", Reg_Write_o); end
    checks++; if (b_ready_o !== 1'b1) begin errors++; $display("FAIL reset_bready got %b want 1", b_ready_o); end
    checks++; if (pending_o !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", pending_o); end
    checks++; if (fifo_count_o !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count_o); end
  endtask

  task automatic test_a_only();
    a_valid_i = 1'b1; a_addr_i = 5'd5; a_data_i = 32'hDEADBEEF;
    #1;
    checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL a_only_ready got %b want 1", a_ready_o); end
    tick();
    checks++; if ({Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL a_only_write got we=%b r=%0d d=%h gb=%b want we=1 r=5 d=deadbeef gb=0",
                        Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o); end
    a_addr_i = 5'd0; a_data_i = 32'h1234;
    #1;
    checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL a_x0_ready got %b want 1", a_ready_o); end
    tick();
    checks++; if (Reg_Write_o !== 1'b0) begin errors++; $display("FAIL a_x0_we got %b want 0", Reg_Write_o); end
    idle();
  endtask

  task automatic test_b_fill();
    a_valid_i = 1'b1; a_addr_i = 5'd1; a_data_i = 32'h100;
    b_valid_i = 1'b1; b_addr_i = 5'd7; b_data_i = 32'h11;
    tick();
    b_addr_i = 5'd9; b_data_i = 32'h22;
    tick();
    checks++; if (b_ready_o !== 1'b0) begin errors++; $display("FAIL fill_bready got %b want 0", b_ready_o); end
    checks++; if (pending_o !== 32'h00000280) begin errors++; $display("FAIL fill_pending got %h want 00000280", pending_o); end
    checks++; if (fifo_count_o !== 2'd2) begin errors++; $display("FAIL fill_count got %0d want 2", fifo_count_o); end
    idle();
    tick();
    checks++; if ({Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o} !== {1'b1, 5'd7, 32'h11, 1'b1}) begin
      errors++; $display("FAIL drain_first got we=%b r=%0d d=%h gb=%b want we=1 r=7 d=11 gb=1",
                        Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o); end
    tick();
    checks++; if ({Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o} !== {1'b1, 5'd9, 32'h22, 1'b1}) begin
      errors++; $display("FAIL drain_second got we=%b r=%0d d=%h gb=%b want we=1 r=9 d=22 gb=1",
                        Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o); end
    checks++; if (pending_o !== 32'h0) begin errors++; $display("FAIL drain_pending got %h want 0", pending_o); end
  endtask

  task automatic test_waw();
    a_valid_i = 1'b1; a_addr_i = 5'd1; a_data_i = 32'h101;
    b_valid_i = 1'b1; b_addr_i = 5'd12; b_data_i = 32'hAA;
    tick();
    b_valid_i = 1'b0;
    a_addr_i = 5'd12; a_data_i = 32'hBB;
    #1;
    checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL waw_block got %b want 0", a_ready_o); end
    checks++; if (pending_o !== 32'h00001000) begin errors++; $display("FAIL waw_pending got %h want 00001000", pending_o); end
    tick();
    checks++; if ({Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o} !== {1'b1, 5'd12, 32'hAA, 1'b1}) begin
      errors++; $display("FAIL waw_b_first got we=%b r=%0d d=%h gb=%b want we=1 r=12 d=aa gb=1",
                        Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o); end
    checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL waw_release got %b want 1", a_ready_o); end
    tick();
    checks++; if ({Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o} !== {1'b1, 5'd12, 32'hBB, 1'b0}) begin
      errors++; $display("FAIL waw_a_last got we=%b r=%0d d=%h gb=%b want we=1 r=12 d=bb gb=0",
                        Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o); end
    idle();
  endtask

  task automatic test_starvation();
    a_valid_i = 1'b1; a_addr_i = 5'd3; a_data_i = 32'h33;
    b_valid_i = 1'b1; b_addr_i = 5'd4; b_data_i = 32'h44;
    tick();
    b_valid_i = 1'b0;
    // Four cycles with the entry visible but A still winning.
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL starve_ready_%0d got %b want 1", i, a_ready_o); end
      tick();
      checks++; if ({Reg_Write_o, Write_Register_o, grant_b_o} !== {1'b1, 5'd3, 1'b0}) begin
        errors++; $display("FAIL starve_a_%0d got we=%b r=%0d gb=%b want we=1 r=3 gb=0", i, Reg_Write_o, Write_Register_o, grant_b_o); end
    end
    checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL starve_force got %b want 0", a_ready_o); end
    tick();
    checks++; if ({Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o} !== {1'b1, 5'd4, 32'h44, 1'b1}) begin
      errors++; $display("FAIL starve_b got we=%b r=%0d d=%h gb=%b want we=1 r=4 d=44 gb=1",
                        Reg_Write_o, Write_Register_o, Write_Data_o, grant_b_o); end
    checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL starve_resume got %b want 1", a_ready_o); end
    tick();
    checks++; if ({Reg_Write_o, Write_Register_o, grant_b_o} !== {1'b1, 5'd3, 1'b0}) begin
      errors++; $display("FAIL starve_a_back got we=%b r=%0d gb=%b want we=1 r=3 gb=0", Reg_Write_o, Write_Register_o, grant_b_o); end
    idle();
  endtask

  task automatic test_concurrent();
    logic [4:0]  q_addr [$];
    logic [31:0] q_data [$];
    logic        acc_a, acc_b, exp_g, exp_gb;
    logic [4:0]  exp_r;
    logic [31:0] exp_d, exp_pend;
    // Directed: push while popping at occupancy 1.
    b_valid_i = 1'b1; b_addr_i = 5'd6; b_data_i = 32'h66;
    tick();
    b_addr_i = 5'd8; b_data_i = 32'h88;
    tick();
    checks++; if (fifo_count_o !== 2'd1) begin errors++; $display("FAIL pushpop_count got %0d want 1", fifo_count_o); end
    checks++; if ({Reg_Write_o, Write_Register_o, Write_Data_o} !== {1'b1, 5'd6, 32'h66}) begin
      errors++; $display("FAIL pushpop_first got we=%b r=%0d d=%h want we=1 r=6 d=66", Reg_Write_o, Write_Register_o, Write_Data_o); end
    b_valid_i = 1'b0;
    tick();
    checks++; if ({Reg_Write_o, Write_Register_o, Write_Data_o, fifo_count_o} !== {1'b1, 5'd8, 32'h88, 2'd0}) begin
      errors++; $display("FAIL pushpop_second got we=%b r=%0d d=%h cnt=%0d want we=1 r=8 d=88 cnt=0",
                        Reg_Write_o, Write_Register_o, Write_Data_o, fifo_count_o); end
    // Random traffic against an in-order queue of accepted B writes.
    for (int c = 0; c < 100; c++) begin
      a_valid_i = ($urandom_range(0, 99) < 60);
      a_addr_i  = 5'($urandom_range(0, 15));
      a_data_i  = $urandom;
      b_valid_i = ($urandom_range(0, 99) < 50);
      b_addr_i  = 5'($urandom_range(0, 15));
      b_data_i  = $urandom;
      #1;
      exp_pend = '0;
      foreach (q_addr[k]) if (q_addr[k] != 5'd0) exp_pend[q_addr[k]] = 1'b1;
      checks++; if (pending_o !== exp_pend) begin errors++; $display("FAIL rnd_pending_%0d got %h want %h", c, pending_o, exp_pend); end
      checks++; if (fifo_count_o !== 2'(q_addr.size())) begin errors++; $display("FAIL rnd_count_%0d got %0d want %0d", c, fifo_count_o, q_addr.size()); end
      acc_a = a_valid_i && a_ready_o;
      acc_b = b_valid_i && (q_addr.size() < 2);
      checks++; if (b_ready_o !== (q_addr.size() < 2)) begin errors++; $display("FAIL rnd_bready_%0d got %b want %b", c, b_ready_o, q_addr.size() < 2); end
      exp_g = 1'b0; exp_gb = 1'b0; exp_r = '0; exp_d = '0;
      if (acc_a) begin
        exp_g = 1'b1; exp_r = a_addr_i; exp_d = a_data_i;
      end else if (q_addr.size() > 0) begin
        exp_g = 1'b1; exp_gb = 1'b1; exp_r = q_addr.pop_front(); exp_d = q_data.pop_front();
      end
      if (acc_b) begin q_addr.push_back(b_addr_i); q_data.push_back(b_data_i); end
      tick();
      checks++; if (Reg_Write_o !== (exp_g && exp_r != 5'd0)) begin
        errors++; $display("FAIL rnd_we_%0d got %b want %b", c, Reg_Write_o, exp_g && exp_r != 5'd0); end
      if (exp_g) begin
        checks++; if ({Write_Register_o, Write_Data_o, grant_b_o} !== {exp_r, exp_d, exp_gb}) begin
          errors++; $display("FAIL rnd_write_%0d got r=%0d d=%h gb=%b want r=%0d d=%h gb=%b",
                            c, Write_Register_o, Write_Data_o, grant_b_o, exp_r, exp_d, exp_gb); end
      end
    end
    idle();
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    a_valid_i = 1'b1; a_addr_i = 5'd1; a_data_i = 32'h55;
    b_valid_i = 1'b1; b_addr_i = 5'd13; b_data_i = 32'hD;
    tick();
    b_addr_i = 5'd14; b_data_i = 32'hE;
    tick();
    idle();
    checks++; if ({fifo_count_o, Reg_Write_o} !== {2'd2, 1'b1}) begin
      errors++; $display("FAIL midrst_pre got cnt=%0d we=%b want cnt=2 we=1", fifo_count_o, Reg_Write_o); end
    reset = 1'b0;
    #1;
    checks++; if (fifo_count_o !== 2'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", fifo_count_o); end
    checks++; if (Reg_Write_o !== 1'b0) begin errors++; $display("FAIL midrst_we got %b want 0", Reg_Write_o); end
    checks++; if (pending_o !== 32'h0) begin errors++; $display("FAIL midrst_pending got %h want 0", pending_o); end
    tick();
    reset = 1'b1;
    tick(); tick();
    checks++; if ({Reg_Write_o, fifo_count_o} !== {1'b0, 2'd0}) begin
      errors++; $display("FAIL midrst_nowrite got we=%b cnt=%0d want we=0 cnt=0", Reg_Write_o, fifo_count_o); end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_fill();
    test_waw();
    test_starvation();
    test_concurrent();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of Register_File between two writeback sources.
- Source A is the single-cycle ALU/load writeback path and has priority.
- Source B is a multi-cycle unit (mul/div or peripheral load). Its requests are buffered in a small FIFO and drained when the port is free.
- The block drives the register file's Reg_Write/Write_Register/Write_Data inputs, prevents write-after-write reordering, and exports a per-register pending mask for hazard stalling.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width (32 registers)
FIFO_DEPTH, 2, source-B buffer entries (power of two, >=2)
MAX_WAIT, 4, cycles a non-empty B FIFO may go ungranted before A is forced to stall

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
a_valid_i  input  1  source A write request
a_ready_o  output  1  source A accepted this cycle (combinational)
a_addr_i  input  ADDR_W  source A destination register
a_data_i  input  DATA_W  source A write data
b_valid_i  input  1  source B write request
b_ready_o  output  1  FIFO not full (combinational from state only)
b_addr_i  input  ADDR_W  source B destination register
b_data_i  input  DATA_W  source B write data
Reg_Write_o  output  1  register file write enable (registered)
Write_Register_o  output  ADDR_W  register file write index (registered)
Write_Data_o  output  DATA_W  register file write data (registered)
grant_b_o  output  1  registered: current write originates from source B
pending_o  output  32  bit r set while any FIFO entry targets register r (r != 0)
fifo_count_o  output  2  current B FIFO occupancy

Behaviour:
Reset (reset low, asynchronous):
- All registered outputs go to 0; FIFO is emptied; wait counter is 0; state is NORMAL.

B FIFO:
- Push when b_valid_i && b_ready_o. b_ready_o = (count != FIFO_DEPTH).
- There is no combinational pass-through: a push and a pop in the same cycle are allowed only when count < FIFO_DEPTH.
- pending_o = OR of one-hot decodes of the addresses of all valid entries; bit 0 is always 0.
- Pointers wrap modulo FIFO_DEPTH.

a_ready_o is low when either of these holds:
- state == FORCE_B, or
- a_addr_i != 0 and pending_o[a_addr_i] == 1 (this blocks write-after-write reordering: the older B write must land first).

Otherwise a_ready_o is 1. It is independent of a_valid_i.

Per-cycle grant:
- If a_valid_i && a_ready_o, grant A.
- Else if FIFO is non-empty, grant B (pop head).
- Else, no grant.

Output register, updated on the next rising edge after a grant:
- Write_Register_o/Write_Data_o take the granted source's addr/data; grant_b_o = (grant is B).
- Reg_Write_o = granted && addr != 0. Writes to x0 complete their handshake/pop but produce no enable.
- With no grant, Reg_Write_o = 0 and the other outputs hold their previous values.
- Latency: exactly 1 cycle from acceptance/pop to Reg_Write_o.

State machine:
- NORMAL: wait_cnt increments each cycle the FIFO is non-empty and B is not granted; it clears on any B grant or when the FIFO is empty.
  - When wait_cnt == MAX_WAIT-1 and B is again not granted, go to FORCE_B.
- FORCE_B: a_ready_o = 0, so B's head is granted that cycle. Return to NORMAL with wait_cnt = 0.
  - FORCE_B lasts exactly one cycle.

Other required behaviour:
- Simultaneous A request and B push into an empty FIFO: A is granted. The B entry becomes visible (pending_o, eligible for pop) the following cycle.
- Reset asserted mid-operation: buffered B entries are discarded, with no write issued for them.
- wait_cnt saturates and never wraps.

Test Plan:
1. Reset released with no requests -> Reg_Write_o=0, b_ready_o=1, pending_o=0, fifo_count_o=0. Assert reset low mid-stream with 2 entries buffered -> fifo_count_o=0 and Reg_Write_o=0 immediately (asynchronously).
2. A only: a_valid_i=1, addr=5, data=0xDEADBEEF -> next edge Reg_Write_o=1, Write_Register_o=5, Write_Data_o=0xDEADBEEF, grant_b_o=0. Repeat with addr=0 -> a_ready_o=1, Reg_Write_o=0.
3. B fill: push B (7,0x11), (9,0x22) on consecutive cycles while A is busy -> b_ready_o=0 at count 2, pending_o=0x00000280. Drop A -> writes to 7 then 9 on consecutive cycles, then pending_o=0.
4. WAW hazard: B entry pending at addr 12 while A requests addr 12 -> a_ready_o=0, B's write to 12 issues first; next cycle a_ready_o=1 and A's value is the final write to 12.
5. Starvation: hold A valid (addr 3) every cycle with one B entry at addr 4 -> after exactly MAX_WAIT=4 ungranted cycles, a_ready_o=0 for one cycle and the next write is addr 4 with grant_b_o=1; A resumes the following cycle.
6. Concurrent push and pop at count 1 -> fifo_count_o stays 1, FIFO order preserved, no lost or duplicated writes over 100 random cycles (scoreboard against a reference model).
